// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA/DVI raster timing generator. A pixel strobe (ce) advances
// the raster by one pixel, so the block can run from a faster system clock.
// Timing comes from the programmable porch/sync widths and sync polarities.
// hsync/vsync/de can be delayed by PIPE_DLY ce-steps to line up with a
// downstream pixel pipeline. x, y and the start pulses are never delayed.
//
// Ports
//   clk          system clock
//   reset        asynchronous assert, active-low reset (release is expected
//                to be synchronised to clk upstream)
//   ce           pixel strobe: one raster step per clk with ce=1
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   de           display enable (visible pixel)
//   x, y         current column / line, CW bits wide
//   line_start   one-clk pulse in the cycle x becomes 0
//   frame_start  one-clk pulse in the cycle (x,y) becomes (0,0)
//   frame_cnt    16-bit count of frames started (VGA_FRAME_CNT_EN only)
//
// Configuration macro
//   VGA_FRAME_CNT_EN  when defined, adds the frame_cnt port and its counter.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 10,
  parameter int unsigned PIPE_DLY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries at counter width. All of them fit because every
  // boundary is below the total, and the total fits in CW bits.
  localparam logic [CW-1:0] X_MAX      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_MAX      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] X_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] X_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] Y_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] Y_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CW == 0 || CW > 16 || PIPE_DLY > 15 ||
      (2**CW) < H_TOTAL || (2**CW) < V_TOTAL) begin : g_bad_params
    $error("vga_timing_gen: illegal parameters (zero width, CW too small or PIPE_DLY > 15)");
  end

  // ---------------------------------------------------------------------------
  // Raster counters, start pulses and registered decode
  // ---------------------------------------------------------------------------
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  // Decode is kept as "active" flags; polarity is applied only at the pins,
  // so the reset value 0 always means "inactive".
  logic          de_act_q, de_act_d;
  logic          hs_act_q, hs_act_d;
  logic          vs_act_q, vs_act_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (ce) begin
      if (x_q == X_MAX) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == Y_MAX) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end

    // Decoding the next coordinates keeps the registered flags aligned with
    // x/y in the same cycle; with ce=0 x_d/y_d equal x_q/y_q, so they hold.
    de_act_d = (x_d < X_ACT_END) && (y_d < Y_ACT_END);
    hs_act_d = (x_d >= X_SYNC_BEG) && (x_d < X_SYNC_END);
    vs_act_d = (y_d >= Y_SYNC_BEG) && (y_d < Y_SYNC_END);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q           <= X_MAX;
      y_q           <= Y_MAX;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      de_act_q      <= 1'b0;
      hs_act_q      <= 1'b0;
      vs_act_q      <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      de_act_q      <= de_act_d;
      hs_act_q      <= hs_act_d;
      vs_act_q      <= vs_act_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional delay line on the decoded flags, advanced only on ce
  // ---------------------------------------------------------------------------
  logic de_out;
  logic hs_out;
  logic vs_out;

  if (PIPE_DLY == 0) begin : g_no_pipe
    assign de_out = de_act_q;
    assign hs_out = hs_act_q;
    assign vs_out = vs_act_q;
  end else begin : g_pipe
    logic [PIPE_DLY-1:0] de_pipe_q, de_pipe_d;
    logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;

    always_comb begin
      de_pipe_d = de_pipe_q;
      hs_pipe_d = hs_pipe_q;
      vs_pipe_d = vs_pipe_q;
      if (ce) begin
        de_pipe_d[0] = de_act_q;
        hs_pipe_d[0] = hs_act_q;
        vs_pipe_d[0] = vs_act_q;
        for (int i = 1; i < PIPE_DLY; i++) begin
          de_pipe_d[i] = de_pipe_q[i-1];
          hs_pipe_d[i] = hs_pipe_q[i-1];
          vs_pipe_d[i] = vs_pipe_q[i-1];
        end
      end
    end

    // NOTE: the delay stages are reset because their contents reach the sync
    // pins directly; an unreset stage would emit bogus sync pulses after reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        de_pipe_q <= '0;
        hs_pipe_q <= '0;
        vs_pipe_q <= '0;
      end else begin
        de_pipe_q <= de_pipe_d;
        hs_pipe_q <= hs_pipe_d;
        vs_pipe_q <= vs_pipe_d;
      end
    end

    assign de_out = de_pipe_q[PIPE_DLY-1];
    assign hs_out = hs_pipe_q[PIPE_DLY-1];
    assign vs_out = vs_pipe_q[PIPE_DLY-1];
  end

  // ---------------------------------------------------------------------------
  // Optional frame counter: steps in the same cycle frame_start is high
  // ---------------------------------------------------------------------------
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_out;
  assign hsync       = HS_POL ? hs_out : ~hs_out;
  assign vsync       = VS_POL ? vs_out : ~vs_out;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
